// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared PWM constants and decoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_CNT_W   = 6;
    localparam int c_PERIOD  = 64;
    localparam int c_TIMEOUT = 128;
    localparam int c_MEAS_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_edge
// Description : Two-flop synchronizer with a delayed copy for rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    output logic o_lvl,
    output logic o_rise
);

    logic r_meta;
    logic r_lvl;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_lvl  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pulse;
            r_lvl  <= r_meta;
            r_prev <= r_lvl;
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_lvl & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_decoder
// Description : Recovers the duty code of a fixed-period PWM line; flags bad
//               periods and stuck lines.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W   = c_CNT_W,
    parameter int PERIOD  = c_PERIOD,
    parameter int TIMEOUT = c_TIMEOUT,
    parameter int MEAS_W  = c_MEAS_W
) (
    input  logic             sysclk,
    input  logic             sysrst_n,
    input  logic             Enable_SW_0,
    input  logic             Pulse_In,
    output logic [CNT_W-1:0] Duty_Cycle,
    output logic             Duty_Valid,
    output logic             Period_Err,
    output logic             Stuck
);

    localparam logic [MEAS_W-1:0] c_PERIOD_M  = MEAS_W'(PERIOD);
    localparam logic [MEAS_W-1:0] c_TIMEOUT_M = MEAS_W'(TIMEOUT);

    logic              w_lvl;
    logic              w_rise;
    logic [MEAS_W-1:0] r_per_cnt;
    logic [MEAS_W-1:0] r_hi_cnt;

    pwm_state_e        r_state;
    pwm_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_duty;
    logic [CNT_W-1:0]  w_duty_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_perr;
    logic              w_perr_nxt;
    logic              r_stuck;
    logic              w_stuck_nxt;

    pulse_sync_edge u_sync (
        .i_clk   (sysclk),
        .i_rst_n (sysrst_n),
        .i_pulse (Pulse_In),
        .o_lvl   (w_lvl),
        .o_rise  (w_rise)
    );

    // Counts include the rise cycle itself, so a clean period reads exactly PERIOD
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (!Enable_SW_0) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_rise) begin
            r_per_cnt <= MEAS_W'(1);
            r_hi_cnt  <= MEAS_W'(1);
        end else begin
            if (r_per_cnt < c_TIMEOUT_M) begin
                r_per_cnt <= r_per_cnt + MEAS_W'(1);
            end
            if (w_lvl && (r_hi_cnt < c_TIMEOUT_M)) begin
                r_hi_cnt <= r_hi_cnt + MEAS_W'(1);
            end
        end
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_valid <= w_valid_nxt;
            r_perr  <= w_perr_nxt;
            r_stuck <= w_stuck_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_valid_nxt = 1'b0;
        w_perr_nxt  = 1'b0;
        w_stuck_nxt = r_stuck;

        if (!Enable_SW_0) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, MEASURE: begin
                    if (w_rise) begin
                        // The first rise after IDLE only opens a full period
                        w_state_nxt = MEASURE;
                        w_stuck_nxt = 1'b0;
                        if (r_state == MEASURE) begin
                            if (r_per_cnt == c_PERIOD_M) begin
                                w_duty_nxt  = r_hi_cnt[CNT_W-1:0];
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_perr_nxt = 1'b1;
                            end
                        end
                    end else if (r_per_cnt == c_TIMEOUT_M) begin
                        w_state_nxt = STUCK;
                        w_stuck_nxt = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_duty_nxt  = w_lvl ? {CNT_W{1'b1}} : '0;
                    end
                end
                STUCK: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURE;
                        w_stuck_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign Duty_Cycle = r_duty;
    assign Duty_Valid = r_valid;
    assign Period_Err = r_perr;
    assign Stuck      = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_decoder
// Description : Directed scoreboard bench for pwm_duty_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_decoder;

    logic       sysclk = 1'b0;
    logic       sysrst_n = 1'b0;
    logic       Enable_SW_0 = 1'b1;
    logic       Pulse_In = 1'b0;
    logic [5:0] Duty_Cycle;
    logic       Duty_Valid;
    logic       Period_Err;
    logic       Stuck;

    pwm_duty_decoder dut (
        .sysclk      (sysclk),
        .sysrst_n    (sysrst_n),
        .Enable_SW_0 (Enable_SW_0),
        .Pulse_In    (Pulse_In),
        .Duty_Cycle  (Duty_Cycle),
        .Duty_Valid  (Duty_Valid),
        .Period_Err  (Period_Err),
        .Stuck       (Stuck)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit perr;
        int duty;
        bit stuck;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Model of what the decoder has seen so far
    bit   armed = 1'b0;
    int   last_rise = 0;
    int   last_hi = 0;
    int   m_duty = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (sysrst_n) begin
            n_cmp++;
            assert (!(Duty_Valid && Period_Err)) else begin
                n_err++;
                $error("FAIL both_strobes observed=1 expected=0");
            end
            if (Duty_Valid || Period_Err) begin
                n_cmp++;
                assert (q.size() !== 0) else begin
                    n_err++;
                    $error("FAIL unexpected_strobe observed=cyc%0d expected=none", cyc);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_cmp++;
                    assert (Period_Err === e.perr) else begin
                        n_err++;
                        $error("FAIL strobe_kind observed=%0d expected=%0d", Period_Err, e.perr);
                    end
                    n_cmp++;
                    assert (int'(Duty_Cycle) === e.duty) else begin
                        n_err++;
                        $error("FAIL duty observed=%0d expected=%0d", Duty_Cycle, e.duty);
                    end
                    n_cmp++;
                    assert (Stuck === e.stuck) else begin
                        n_err++;
                        $error("FAIL stuck_at_strobe observed=%0d expected=%0d", Stuck, e.stuck);
                    end
                    n_cmp++;
                    assert (cyc === e.cyc) else begin
                        n_err++;
                        $error("FAIL strobe_cycle observed=%0d expected=%0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input bit perr, input int duty, input bit stuck, input int at);
        exp_t e;
        e.perr  = perr;
        e.duty  = duty;
        e.stuck = stuck;
        e.cyc   = at;
        q.push_back(e);
    endtask

    // A driven rise closes the previous period; its result appears 3 cycles later
    task automatic rise_event(input int hi);
        if (armed) begin
            if (cyc - last_rise == 64) begin
                push(1'b0, last_hi, 1'b0, cyc + 3);
                m_duty = last_hi;
            end else begin
                push(1'b1, m_duty, 1'b0, cyc + 3);
            end
        end
        armed     = 1'b1;
        last_rise = cyc;
        last_hi   = hi;
    endtask

    task automatic pwm(input int per, input int hi, input int n);
        if (Pulse_In) begin
            Pulse_In = 1'b0;
            tick(2);
        end
        repeat (n) begin
            rise_event(hi);
            Pulse_In = 1'b1;
            tick(hi);
            Pulse_In = 1'b0;
            tick(per - hi);
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        if (lvl && !Pulse_In) begin
            rise_event(0);
            Pulse_In = 1'b1;
        end
        m_duty = lvl ? 63 : 0;
        push(1'b0, m_duty, 1'b1, last_rise + 131);
        armed = 1'b0;
        tick(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        check("rst_duty", Duty_Cycle, 0);
        check("rst_valid", Duty_Valid, 0);
        check("rst_perr", Period_Err, 0);
        check("rst_stuck", Stuck, 0);
        sysrst_n = 1'b1;
        tick(2);

        pwm(64, 21, 5);
        pwm(64, 1, 2);
        pwm(64, 33, 2);
        pwm(64, 63, 2);

        hold(1'b0, 200);
        check("stuck_low_level", Stuck, 1);
        check("stuck_low_duty", Duty_Cycle, 0);

        pwm(64, 10, 2);
        check("stuck_cleared", Stuck, 0);
        hold(1'b1, 200);
        check("stuck_high_level", Stuck, 1);
        check("stuck_high_duty", Duty_Cycle, 63);

        pwm(50, 20, 4);
        check("perr_duty_held", Duty_Cycle, 63);
        pwm(64, 21, 3);

        // Asynchronous reset mid-period
        #2;
        sysrst_n = 1'b0;
        #1;
        check("arst_duty", Duty_Cycle, 0);
        check("arst_valid", Duty_Valid, 0);
        check("arst_perr", Period_Err, 0);
        check("arst_stuck", Stuck, 0);
        check("arst_queue", q.size(), 0);
        armed  = 1'b0;
        m_duty = 0;
        tick(3);
        sysrst_n = 1'b1;
        pwm(64, 45, 3);

        // Disable with a pulse that must be ignored
        Enable_SW_0 = 1'b0;
        tick(1);
        Pulse_In = 1'b1;
        tick(4);
        Pulse_In = 1'b0;
        tick(5);
        check("dis_duty_held", Duty_Cycle, m_duty);
        check("dis_stuck_held", Stuck, 0);
        Enable_SW_0 = 1'b1;
        armed = 1'b0;
        pwm(64, 12, 3);

        tick(10);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
Receive-side counterpart of the 6-bit breathing-LED PWM generator. Samples an asynchronous PWM line and measures high time and period between rising edges. When the period is exactly PERIOD cycles, it reports the recovered duty-cycle code with a one-cycle valid strobe. It flags bad periods and detects stuck-low/stuck-high lines; used for loopback checking and for decoding PWM from an adjacent board.

Parameters:
CNT_W, 6, width of recovered duty code; PERIOD = 2**CNT_W
PERIOD, 64, expected PWM period in sysclk cycles
TIMEOUT, 128, cycles without a rising edge before declaring line stuck; must be > PERIOD
MEAS_W, 8, measurement counter width; must hold TIMEOUT

Ports:
sysclk  input  1  system clock, all logic rising-edge
sysrst_n  input  1  asynchronous active-low reset
Enable_SW_0  input  1  decoder enable; low forces IDLE, outputs held
Pulse_In  input  1  asynchronous PWM line
Duty_Cycle  output  CNT_W  last recovered duty code
Duty_Valid  output  1  one-cycle strobe when Duty_Cycle updated
Period_Err  output  1  one-cycle strobe when measured period != PERIOD
Stuck  output  1  level; line has had no rising edge for TIMEOUT cycles

Behaviour:
- Reset (async, sysrst_n=0): Duty_Cycle=0, Duty_Valid=0, Period_Err=0, Stuck=0, state=IDLE, counters=0, synchronizer flops=0.
- Front end: 2-flop synchronizer -> lvl; prev flop; rise = lvl & ~prev. Pulse_In edge to rise = 3 cycles.
- Counters (MEAS_W bits): per_cnt, hi_cnt. On a rise cycle both load 1. Otherwise per_cnt increments, saturating at TIMEOUT, and hi_cnt increments when lvl=1, saturating.
- States: IDLE, MEASURE, STUCK.
- IDLE: counters run. First rise -> MEASURE with no output strobe, because the first period is partial. per_cnt reaching TIMEOUT -> STUCK.
- MEASURE, on rise: if the old per_cnt == PERIOD, Duty_Cycle <= hi_cnt[CNT_W-1:0] and Duty_Valid=1 the next cycle. Otherwise Period_Err=1 the next cycle and Duty_Cycle holds. Stay in MEASURE.
- MEASURE, no rise and per_cnt reaches TIMEOUT: -> STUCK.
- STUCK entry: Stuck=1. Duty_Cycle <= 0 if lvl=0, else all-ones (2**CNT_W-1). One Duty_Valid strobe on entry only.
- STUCK exit: a rise -> MEASURE with Stuck=0 in the same cycle as the transition. No strobe; the next full period is required.
- Generator duty D (0<D<PERIOD): hi_cnt = D and per_cnt = PERIOD at each rise, so Duty_Cycle = D. D=0 gives a constant-low line, which resolves via STUCK to 0.
- Simultaneous rise and per_cnt==TIMEOUT: rise wins; the period is measured, is != PERIOD, and gives Period_Err.
- Enable_SW_0=0: synchronous return to IDLE, counters cleared, strobes 0, Duty_Cycle and Stuck held. Re-enable restarts from IDLE.
- Duty_Valid and Period_Err are never both 1 in the same cycle.

Decomposition:
- Package pwm_pkg holds CNT_W, PERIOD, TIMEOUT and MEAS_W defaults, plus the state enum {IDLE, MEASURE, STUCK}. The generator will also use it.
- One sub-module, pulse_sync_edge: 2-flop synchronizer plus prev flop, outputs lvl and rise, async active-low reset.
- Counters, FSM and output registers stay in pwm_duty_decoder.

Test Plan:
- PWM D=21, period 64, repeated 5 periods -> first valid after second rise, Duty_Cycle=21; Duty_Valid strobes every 64 cycles; no Period_Err.
- Step D through 1, 33, 63 (generator table extremes) -> Duty_Cycle tracks 1, 33, 63, each reported one period after the change.
- Constant low for 200 cycles from a running state -> Stuck=1 and Duty_Cycle=0 128 cycles after the last rise, single Duty_Valid. Constant high -> Duty_Cycle=63, Stuck=1.
- Period 50 with high time 20 -> Period_Err strobes each rise, Duty_Valid never asserts, Duty_Cycle holds its prior value.
- Assert sysrst_n=0 mid-period -> all outputs 0 immediately (async). After release, first valid appears only after two rises.
- Drop Enable_SW_0 for 10 cycles mid-stream -> no strobes while low, Duty_Cycle held; valid resumes on the second rise after re-enable.
